// File: rtl/uart_tx_sched_pkg.sv
// Shared UART transmit definitions used by the uart_tx_sched scheduler and the shift_tx shifter.
// Frame layout is 8N1, with bit 0 shifted out first.
package uart_tx_pkg;

  localparam int FRAME_WIDTH = 10;
  localparam int GAP_WIDTH = 16;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic [FRAME_WIDTH-1:0] LINE_IDLE = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    GAP
  } sched_state_t;

  // The start bit sits in the LSB so that the shifter can simply shift right.
  function automatic logic [FRAME_WIDTH-1:0] make_frame(input logic [7:0] data);
    return {STOP_BIT, data, START_BIT};
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and shifter handshake bundle for uart_tx_sched.
// The master side is the scheduler; the slave side is the requesters together with the shifter.
interface uart_tx_sched_if #(
  parameter int N_REQ = 4
);
  import uart_tx_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [8*N_REQ-1:0]     req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       grant;
  logic                   tx_start;
  logic [FRAME_WIDTH-1:0] tx_frame;
  logic                   frame_sent;
  logic                   busy;

  modport master (
    input  req, req_data, req_last, frame_sent,
    output grant, tx_start, tx_frame, busy
  );

  modport slave (
    output req, req_data, req_last, frame_sent,
    input  grant, tx_start, tx_frame, busy
  );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick for uart_tx_sched.
// Selects the first requester at or after rr_ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic             any
);

  logic found;

  // The outer loop walks the priority order; the inner loop maps that position to a requester index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (((int'(rr_ptr) + k) % N_REQ) == i)) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART shifter between N_REQ byte producers.
// Define UART_TX_SCHED_LOCK_EN to hold arbitration on one requester until its req_last byte.
module uart_tx_sched
  import uart_tx_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 0
) (
  input logic            hwclk,
  input logic            rst,
  uart_tx_sched_if.master bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [GAP_WIDTH-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  sched_state_t           state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic [FRAME_WIDTH-1:0] frame_q;
  logic                   start_q;
  logic                   busy_q;

  logic [N_REQ-1:0] rr_winner;
  logic             rr_any;
  logic [N_REQ-1:0] sel_onehot;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [7:0]       sel_data;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .winner (rr_winner),
    .any    (rr_any)
  );

`ifdef UART_TX_SCHED_LOCK_EN
  logic             lock_valid;
  logic [PTR_W-1:0] lock_idx;
  logic             lock_hit;
  logic             sel_last;

  assign lock_hit = lock_valid && bus.req[lock_idx];

  // A locked requester that is still asking overrides the rotating pick.
  always_comb begin
    sel_onehot = rr_winner;
    if (lock_hit) begin
      sel_onehot           = '0;
      sel_onehot[lock_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_onehot[i]) begin
        sel_last = bus.req_last[i];
      end
    end
  end

  // A byte without req_last keeps the lock; if the locked requester goes quiet, the lock is dropped.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      lock_valid <= 1'b0;
      lock_idx   <= '0;
    end else if (state == IDLE) begin
      if (rr_any) begin
        lock_valid <= !sel_last;
        lock_idx   <= sel_idx;
      end else if (lock_valid && !lock_hit) begin
        lock_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_last;

  assign sel_onehot  = rr_winner;
  assign unused_last = ^bus.req_last;
`endif

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_onehot[i]) begin
        sel_idx  = PTR_W'(i);
        sel_data = bus.req_data[8*i +: 8];
      end
    end
  end

  assign next_ptr = (int'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + PTR_W'(1);

  // Grant is combinational so a request seen on the cycle IDLE is re-entered is accepted without a bubble.
  assign bus.grant = (state == IDLE && !rst) ? sel_onehot : '0;

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gap_cnt <= '0;
      frame_q <= LINE_IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_any) begin
            frame_q <= make_frame(sel_data);
            rr_ptr  <= next_ptr;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.frame_sent) begin
            frame_q <= LINE_IDLE;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_start = start_q;
  assign bus.tx_frame = frame_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmit shifter between `N_REQ` byte producers. It accepts one byte at a time from the winning requester and wraps it in a 10-bit 8N1 frame. It hands the frame to the shifter with a one-cycle start pulse, then waits for the shifter's completion pulse before arbitrating again. It sits between the application requesters and the `shift_tx` shifter in the `hwclk` domain.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `GAP_CYCLES`, 0 — idle `hwclk` cycles inserted after each frame completes, 0..65535.
- `hwclk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N_REQ  per-requester byte valid; held until granted.
- `req_data`  in  8*N_REQ  byte for requester i at `[8i+7:8i]`.
- `req_last`  in  N_REQ  byte ends a message; used only with lock feature.
- `grant`  out  N_REQ  one-hot, one-cycle accept strobe; byte captured on that edge.
- `tx_start`  out  1  one-cycle pulse: `tx_frame` valid, shifter must begin.
- `tx_frame`  out  10  frame, bit0 shifted first: `{1'b1, data[7:0], 1'b0}`.
- `frame_sent`  in  1  one-cycle pulse from shifter, `hwclk`-synchronous, after stop bit.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, WAIT, GAP.
- IDLE:
  - If any `req`, the winner is the first requesting index at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - `grant[winner]` is driven combinationally this cycle.
  - On the clock edge: capture `req_data` slice into the frame register, set `rr_ptr = winner+1` (wraps to 0), go to LOAD.
  - With no `req`, stay in IDLE and drive no grant.
- LOAD: `tx_start=1` for exactly one cycle, `tx_frame` holds the captured frame; go to WAIT.
- WAIT:
  - `tx_frame` stays stable.
  - On `frame_sent`, go to GAP if `GAP_CYCLES>0`, else go to IDLE.
- GAP:
  - Counter loads `GAP_CYCLES-1` on entry and decrements each cycle.
  - At 0, go to IDLE.
- `frame_sent` outside WAIT is ignored; it is neither counted nor stored.
- After `frame_sent`, `tx_frame` returns to 10'h3FF (line-idle) and stays there until the next LOAD.
- A requester dropping `req` while not granted is legal and is simply skipped.
- Gap counter is 16 bits.

## Timing
- Reset values: `grant=0`, `tx_start=0`, `tx_frame=10'h3FF`, `busy=0`, state IDLE, `rr_ptr=0`, gap counter 0, lock clear.
- `rst` asserted mid-frame aborts immediately to the reset values. The shifter is reset by the same `rst`.
- `req` high in IDLE at cycle 0: `grant` high at cycle 0, `tx_start` high at cycle 1.
- Minimum spacing between grants is 3 cycles plus the frame time plus `GAP_CYCLES`.
- `req` seen in the same cycle the FSM returns to IDLE is granted in that cycle; no bubble.
- `grant` is never asserted outside IDLE. At most one `grant` bit is high at a time.

## Configuration
- `UART_TX_SCHED_LOCK_EN` defined:
  - When a granted byte has `req_last=0`, the scheduler locks to that requester.
  - While locked, the next IDLE arbitration grants only that requester, provided its `req` is high.
  - If its `req` is low in IDLE, the lock releases and normal round-robin applies in that same cycle.
  - A granted byte with `req_last=1` clears the lock.
  - `rr_ptr` still advances past the locked requester on every grant.
- Undefined: `req_last` is ignored and every byte is arbitrated independently.

## Structure
- Package `uart_tx_pkg`:
  - `FRAME_WIDTH=10`, `START_BIT=1'b0`, `STOP_BIT=1'b1`, `LINE_IDLE=10'h3FF`.
  - State enum `sched_state_t`.
  - Shared by this block and the shifter.
- Sub-module `rr_arbiter`: combinational priority rotate.
  - Inputs `req`, `rr_ptr`; outputs one-hot `winner` and `any`.
  - Parameterised on `N_REQ`.
  - The FSM, frame register, gap counter and lock logic stay in `uart_tx_sched`.

## Test plan
- Reset, then requester 2 sends 0xA5: `grant=4'b0100` for one cycle, next cycle `tx_start=1` with `tx_frame=10'b1_10100101_0`; `busy` low after `frame_sent`.
- `req=4'b1111` held, `GAP_CYCLES=0`, `frame_sent` 20 cycles after each `tx_start`: grant order 0,1,2,3,0; never two grants within one frame.
- `GAP_CYCLES=5`: exactly 5 idle cycles between the `frame_sent` pulse and the next `grant`.
- Spurious `frame_sent` in IDLE, then a request: no state change on the spurious pulse, and the following frame still waits for its own `frame_sent`.
- `rst` pulsed during WAIT: `tx_frame=10'h3FF`, `busy=0` asynchronously; after release, requester 1 is granted first when only it requests.
- With `UART_TX_SCHED_LOCK_EN`, requester 1 sends three bytes with `req_last=0,0,1` while requester 0 also requests: grants 1,1,1,0.
- Same `req_last=0,0,1` stimulus without the macro: grants alternate 1,0,1,0.
